// File: rtl/fb_readout_streamer.sv
// Frame buffer reader: walks every pixel in display order and streams it out on valid/ready
// with end-of-row / end-of-frame markers, using a 2-entry credit-managed skid FIFO.
module fb_readout_streamer #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned FLIP_Y = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fb_re,
  output logic [ADDR_W-1:0] o_fb_addr,
  input  logic [PIX_W-1:0]  i_fb_data,
  output logic              o_pix_valid,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_eol,
  output logic              o_pix_eof,
  input  logic              i_pix_ready
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = $clog2(HEIGHT + 1);
  localparam int unsigned EW = PIX_W + 2;
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] FIRST_BASE =
    (FLIP_Y != 0) ? ADDR_W'((HEIGHT - 1) * WIDTH) : {ADDR_W{1'b0}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [XW-1:0]       x, cur_x;
  logic [RW-1:0]       row, cur_row;
  logic [ADDR_W-1:0]   row_base, cur_base;
  logic                last_col, last_row, issue;
  logic                re_eol, re_eof;
  logic                rd_vld, rd_eol, rd_eof;
  logic [EW-1:0]       mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          occ, occ_n;
  logic [EW-1:0]       head;
  logic                pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Stream head: stored entry when occupied, otherwise the word returning from the BRAM this cycle
  always_comb begin
    head        = (occ != 2'd0) ? mem[rd_ptr] : {rd_eof, rd_eol, i_fb_data};
    o_pix_valid = (occ != 2'd0) || rd_vld;
    o_pix_data  = o_pix_valid ? head[PIX_W-1:0] : {PIX_W{1'b0}};
    o_pix_eol   = o_pix_valid & head[PIX_W];
    o_pix_eof   = o_pix_valid & head[PIX_W+1];
    pop         = o_pix_valid & i_pix_ready;
    occ_n       = occ + 2'(rd_vld) - 2'(pop);
  end

  // Next state and read issue; a new read needs a free slot counting the read already on the bus
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    cur_x    = x;
    cur_row  = row;
    cur_base = row_base;
    if (state == IDLE) begin
      cur_x    = '0;
      cur_row  = '0;
      cur_base = FIRST_BASE;
    end
    last_col = (cur_x == XW'(WIDTH - 1));
    last_row = (cur_row == RW'(HEIGHT - 1));
    case (state)
      IDLE:    issue = i_start;
      READ:    issue = (({1'b0, occ_n} + 3'(o_fb_re)) < 3'd2);
      default: issue = 1'b0;
    endcase
    case (state)
      IDLE, READ: if (issue) state_n = (last_col && last_row) ? DRAIN : READ;
      DRAIN:      if ((occ == 2'd0) && !o_fb_re && !rd_vld) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      row       <= '0;
      row_base  <= '0;
      o_fb_re   <= 1'b0;
      o_fb_addr <= '0;
      re_eol    <= 1'b0;
      re_eof    <= 1'b0;
      rd_vld    <= 1'b0;
      rd_eol    <= 1'b0;
      rd_eof    <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_fb_re <= issue;
      if (issue) begin
        o_fb_addr <= cur_base + ADDR_W'(cur_x);
        re_eol    <= last_col;
        re_eof    <= last_col & last_row;
        if (last_col) begin
          x   <= '0;
          row <= cur_row + RW'(1);
          // The final row keeps its base so the address never steps past the buffer
          if (last_row)         row_base <= cur_base;
          else if (FLIP_Y != 0) row_base <= cur_base - ROW_STEP;
          else                  row_base <= cur_base + ROW_STEP;
        end else begin
          x        <= cur_x + XW'(1);
          row      <= cur_row;
          row_base <= cur_base;
        end
      end
      rd_vld <= o_fb_re;
      rd_eol <= re_eol;
      rd_eof <= re_eof;
      if (rd_vld) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      occ    <= occ_n;
      o_busy <= (state_n != IDLE);
      o_done <= (state_n == DONE);
    end
  end

  // Returned data is always captured; credit guarantees a free slot
  always_ff @(posedge clk) begin
    if (rd_vld) mem[wr_ptr] <= {rd_eof, rd_eol, i_fb_data};
  end

endmodule

// File: doc/fb_readout_streamer.md
Name: fb_readout_streamer

Overview:
- Hardware reader for the 320x240x12 frame buffer BRAM; the rasterizer is the writer.
- On i_start it walks every pixel in display order, top row first. With FLIP_Y=1 the last buffer row is emitted first.
- Pixels leave on a valid/ready stream with row and frame markers, feeding a UART/host dump path that replaces the simulation-only backdoor image dump.
- Sits beside the VGA scanout on the frame buffer's second read port.

Parameters:
- WIDTH, 320, pixels per row.
- HEIGHT, 240, rows per frame.
- PIX_W, 12, pixel width, {R[11:8],G[7:4],B[3:0]}.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- FLIP_Y, 1, 1 = emit buffer row HEIGHT-1 first; 0 = emit row 0 first.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  frame dump request; sampled only in IDLE.
- o_busy  out  1  high from the cycle after an accepted i_start until o_done.
- o_done  out  1  one-cycle pulse after the final pixel handshake.
- o_fb_re  out  1  frame buffer read enable.
- o_fb_addr  out  ADDR_W  frame buffer read address.
- i_fb_data  in  PIX_W  read data, valid exactly 1 cycle after o_fb_re.
- o_pix_valid  out  1  stream valid.
- o_pix_data  out  PIX_W  stream pixel.
- o_pix_eol  out  1  marks the last pixel of an emitted row.
- o_pix_eof  out  1  marks the last pixel of the frame (o_pix_eol is also set).
- i_pix_ready  in  1  stream ready from the sink.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_fb_re=0, o_fb_addr=0, o_pix_valid=0, o_pix_data=0, o_pix_eol=0, o_pix_eof=0. Counters zeroed, skid FIFO emptied, FSM in IDLE.
- FSM states:
  - IDLE: i_start=1 -> READ. Loads x=0, row=0, row_base = FLIP_Y ? (HEIGHT-1)*WIDTH : 0.
  - READ: issues reads while credit allows. After the read of the final pixel -> DRAIN.
  - DRAIN: waits until the skid FIFO is empty and no read is in flight, then -> DONE.
  - DONE: asserts o_done for one cycle -> IDLE.
- Addressing: o_fb_addr = row_base + x, with no multiplier.
  - At x = WIDTH-1: x <= 0 and row_base <= row_base -/+ WIDTH (minus for FLIP_Y=1, plus for FLIP_Y=0).
  - After the final read the row counter reaches HEIGHT; the address never wraps or underflows.
- Credit and backpressure:
  - Output uses a 2-entry skid FIFO.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2, so returned data always has space.
  - The BRAM has no stall input, so data is captured on return unconditionally.
- Sideband bits: eol and eof are computed at read-issue time and pipelined alongside the read so they stay aligned with their pixel.
- Output stream:
  - o_pix_* is driven from the FIFO head.
  - A handshake occurs when valid & ready; the FIFO pops on handshake.
  - While valid=1 and ready=0, data, eol and eof hold stable.
  - Simultaneous push and pop in the same cycle is legal.
- Latency: i_start sampled at edge N -> o_fb_re=1 with the first address in cycle N+1 -> o_pix_valid=1 in cycle N+2.
- Throughput: 1 pixel/cycle sustained when i_pix_ready=1 continuously. The full frame takes WIDTH*HEIGHT + 3 cycles from i_start to o_done.
- o_busy rises at N+1 and falls in the cycle after o_done.
- i_start while busy is ignored; no restart and no queued request.
- Reset mid-frame aborts the dump immediately. The next cycle shows all outputs at reset values, and no o_done is produced for the aborted frame.
- o_fb_re is low whenever no read is issued. o_fb_addr holds its last value.

Test Plan:
1. Default params, FB preloaded with ram[i]=i[11:0], ready=1, pulse start:
   - First pixel = ram[76480] = 12'hAC0, then 12'hAC1 ...; eol on pixel 319 (value 12'hBFF).
   - Last pixel = ram[319] = 12'h13F with eof=1.
   - o_done exactly 76803 cycles after start; exactly 76800 handshakes.
2. WIDTH=4, HEIGHT=3, FLIP_Y=0, ram[i]=i, ready=1:
   - Stream 0..11.
   - eol on 3, 7, 11; eof only on 11.
3. WIDTH=4, HEIGHT=3, FLIP_Y=1, ready toggling 1,0,0,1 repeating:
   - Order 8,9,10,11,4..7,0..3.
   - Data held stable during every ready=0 cycle; no pixel dropped or duplicated.
4. Ready held 0 for 50 cycles after start:
   - At most 2 reads issued; o_pix_valid=1 with pixel 0 stable.
   - On release, the stream resumes in order.
5. Start pulsed again at cycle 100 of a dump:
   - Ignored; a single o_done; handshake count unchanged (76800).
6. rst asserted at pixel 1000:
   - Next cycle: o_pix_valid=0, o_busy=0, o_fb_re=0, o_done never pulses.
   - A fresh start then restarts from the first pixel (12'hAC0 in scenario 1 data).
